// File: rtl/lsu_retire_tracker_pkg.sv
// Shared widths and types for the LSU retire tracker.
//  WF_PER_CU    wavefronts per compute unit
//  LSU_WFID_W   wavefront id width
//  LSU_BEAT_W   per-op response beat count width
//  LSU_DEPTH    max outstanding ops (power of two)
package lsu_retire_tracker_pkg;

    localparam int unsigned WF_PER_CU  = 40;
    localparam int unsigned LSU_WFID_W = 6;
    localparam int unsigned LSU_BEAT_W = 4;
    localparam int unsigned LSU_DEPTH  = 8;

    // Head-of-queue state: nothing queued, or collecting beats for the head op
    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_COLLECT = 1'b1
    } head_state_e;

endpackage

// File: rtl/lsu_op_fifo.sv
// In-order synchronous FIFO of accepted LSU ops.
//  clk, rst     clock, async active-high reset
//  i_push       write i_wdata at tail (caller guarantees not full)
//  i_pop        drop head entry (caller guarantees not empty)
//  i_wdata      entry to write
//  o_rdata_c    head entry (combinational read of storage)
//  o_count      registered occupancy, 0..DEPTH
//  o_full_c     occupancy == DEPTH
//  o_empty_c    occupancy == 0
module lsu_op_fifo #(
    parameter  int unsigned DATA_W = 10,
    parameter  int unsigned DEPTH  = 8,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata_c,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full_c,
    output logic              o_empty_c
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Storage needs no reset: entries are only read once written
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count carries full/empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata_c = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_full_c  = (r_count == CNT_W'(DEPTH));
    assign o_empty_c = (r_count == '0);

endmodule

// File: rtl/lsu_retire_tracker.sv
// Tracks LSU ops in issue order and pulses lsu_done/lsu_done_wfid when the
// head op has received its last response beat.
//  clk, rst         clock, async active-high reset
//  issue_valid      LSU accepted an op this cycle
//  issue_wfid       wavefront id of that op
//  issue_beats      response beats expected (0 = none, retires at head)
//  issue_ready      queue has room this cycle
//  mem_rsp_valid    one response beat for the oldest op
//  lsu_done         one-cycle completion pulse (registered)
//  lsu_done_wfid    wfid of the completing op
//  outstanding_cnt  ops queued and not yet retired
//  err_overflow     sticky: issue while not ready
//  err_unexp_rsp    sticky: response beat with nothing queued
module lsu_retire_tracker
    import lsu_retire_tracker_pkg::*;
#(
    parameter  int unsigned WFID_W = LSU_WFID_W,
    parameter  int unsigned DEPTH  = LSU_DEPTH,
    parameter  int unsigned BEAT_W = LSU_BEAT_W,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
    localparam int unsigned OP_W   = WFID_W + BEAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [WFID_W-1:0] issue_wfid,
    input  logic [BEAT_W-1:0] issue_beats,
    output logic              issue_ready,
    input  logic              mem_rsp_valid,
    output logic              lsu_done,
    output logic [WFID_W-1:0] lsu_done_wfid,
    output logic [CNT_W-1:0]  outstanding_cnt,
    output logic              err_overflow,
    output logic              err_unexp_rsp
);

    head_state_e       r_state;
    head_state_e       w_state_nxt;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic              r_done;
    logic [WFID_W-1:0] r_done_wfid;
    logic              r_err_ovf;
    logic              r_err_unexp;

    logic              w_ready;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_retire;
    logic              w_beat_inc;
    logic              w_unexp;
    logic [OP_W-1:0]   w_head;
    logic [WFID_W-1:0] w_head_wfid;
    logic [BEAT_W-1:0] w_head_beats;
    logic [BEAT_W-1:0] w_beat_next;
    logic [CNT_W-1:0]  w_count;

    // Readiness comes from occupancy alone, never from a same-cycle retire
    assign w_ready = !w_full;
    assign w_push  = issue_valid & w_ready;

    lsu_op_fifo #(
        .DATA_W (OP_W),
        .DEPTH  (DEPTH)
    ) u_op_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_pop     (w_retire),
        .i_wdata   ({issue_wfid, issue_beats}),
        .o_rdata_c (w_head),
        .o_count   (w_count),
        .o_full_c  (w_full),
        .o_empty_c (w_empty)
    );

    assign w_head_wfid  = w_head[OP_W-1 -: WFID_W];
    assign w_head_beats = w_head[BEAT_W-1:0];
    assign w_beat_next  = r_beat_cnt + BEAT_W'(1);

    // Head FSM: decide retire / beat count / unexpected beat
    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        w_beat_inc  = 1'b0;
        w_unexp     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                w_unexp = mem_rsp_valid;
                if (w_push) begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // A beat arriving while a zero-beat op sits at head is not counted
                w_retire   = !w_empty &&
                             ((w_head_beats == '0) ||
                              (mem_rsp_valid && (w_beat_next == w_head_beats)));
                w_beat_inc = mem_rsp_valid && !w_retire;
                if (w_retire && (w_count == CNT_W'(1)) && !w_push) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // State, beat counter, done pulse and sticky errors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_beat_cnt  <= '0;
            r_done      <= 1'b0;
            r_done_wfid <= '0;
            r_err_ovf   <= 1'b0;
            r_err_unexp <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_retire) begin
                r_beat_cnt <= '0;
            end else if (w_beat_inc) begin
                r_beat_cnt <= w_beat_next;
            end
            r_done <= w_retire;
            if (w_retire) begin
                r_done_wfid <= w_head_wfid;
            end
            if (issue_valid && !w_ready) begin
                r_err_ovf <= 1'b1;
            end
            if (w_unexp) begin
                r_err_unexp <= 1'b1;
            end
        end
    end

    assign issue_ready     = w_ready;
    assign lsu_done        = r_done;
    assign lsu_done_wfid   = r_done_wfid;
    assign outstanding_cnt = w_count;
    assign err_overflow    = r_err_ovf;
    assign err_unexp_rsp   = r_err_unexp;

endmodule

// File: tb/tb_lsu_retire_tracker.sv
// Directed bench for lsu_retire_tracker; outputs sampled 1 time unit after
// each rising edge, inputs changed at the same point.
module tb_lsu_retire_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic [5:0] issue_wfid;
    logic [3:0] issue_beats;
    logic       issue_ready;
    logic       mem_rsp_valid;
    logic       lsu_done;
    logic [5:0] lsu_done_wfid;
    logic [3:0] outstanding_cnt;
    logic       err_overflow;
    logic       err_unexp_rsp;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    lsu_retire_tracker dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_wfid      (issue_wfid),
        .issue_beats     (issue_beats),
        .issue_ready     (issue_ready),
        .mem_rsp_valid   (mem_rsp_valid),
        .lsu_done        (lsu_done),
        .lsu_done_wfid   (lsu_done_wfid),
        .outstanding_cnt (outstanding_cnt),
        .err_overflow    (err_overflow),
        .err_unexp_rsp   (err_unexp_rsp)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic set_issue(input logic v, input logic [5:0] w, input logic [3:0] b);
        issue_valid = v;
        issue_wfid  = w;
        issue_beats = b;
    endtask

    initial begin
        logic [5:0] drain_wfid [7];
        drain_wfid = '{6'd13, 6'd14, 6'd15, 6'd16, 6'd17, 6'd20, 6'd21};

        rst = 1'b1;
        set_issue(1'b0, 6'd0, 4'd0);
        mem_rsp_valid = 1'b0;
        cyc();
        cyc();
        chk("rst_ready", 32'(issue_ready), 1);
        chk("rst_cnt", 32'(outstanding_cnt), 0);
        chk("rst_done", 32'(lsu_done), 0);
        chk("rst_done_wfid", 32'(lsu_done_wfid), 0);
        chk("rst_err_ovf", 32'(err_overflow), 0);
        chk("rst_err_unexp", 32'(err_unexp_rsp), 0);
        rst = 1'b0;

        // 1: three ops queued, then reset discards them
        set_issue(1'b1, 6'd1, 4'd2); cyc();
        set_issue(1'b1, 6'd2, 4'd2); cyc();
        set_issue(1'b1, 6'd3, 4'd2); cyc();
        set_issue(1'b0, 6'd0, 4'd0);
        chk("t1_cnt3", 32'(outstanding_cnt), 3);
        rst = 1'b1;
        #2;
        chk("t1_rst_cnt", 32'(outstanding_cnt), 0);
        chk("t1_rst_done", 32'(lsu_done), 0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t1_no_pulse", 32'(lsu_done), 0);
        end

        // 2: wfid 5, 3 beats at t+2, t+4, t+5 -> done at t+6
        set_issue(1'b1, 6'd5, 4'd3); cyc();          // now t+1
        set_issue(1'b0, 6'd0, 4'd0);
        chk("t2_cnt1", 32'(outstanding_cnt), 1);
        cyc();                                        // t+2
        mem_rsp_valid = 1'b1; cyc();                  // t+3
        mem_rsp_valid = 1'b0;
        chk("t2_done_t3", 32'(lsu_done), 0);
        cyc();                                        // t+4
        mem_rsp_valid = 1'b1; cyc();                  // t+5
        chk("t2_done_t5", 32'(lsu_done), 0);
        cyc();                                        // t+6
        mem_rsp_valid = 1'b0;
        chk("t2_done", 32'(lsu_done), 1);
        chk("t2_wfid", 32'(lsu_done_wfid), 5);
        chk("t2_cnt0", 32'(outstanding_cnt), 0);
        cyc();
        chk("t2_done_off", 32'(lsu_done), 0);

        // 3: wfid 0/1 beat, 7/0 beats, 39/2 beats; 7 retires in the idle slot
        set_issue(1'b1, 6'd0, 4'd1); cyc();
        set_issue(1'b1, 6'd7, 4'd0); cyc();
        set_issue(1'b1, 6'd39, 4'd2); cyc();
        set_issue(1'b0, 6'd0, 4'd0);
        chk("t3_cnt3", 32'(outstanding_cnt), 3);
        mem_rsp_valid = 1'b1; cyc();
        mem_rsp_valid = 1'b0;
        chk("t3_done0", 32'(lsu_done), 1);
        chk("t3_wfid0", 32'(lsu_done_wfid), 0);
        cyc();
        mem_rsp_valid = 1'b1;
        chk("t3_done7", 32'(lsu_done), 1);
        chk("t3_wfid7", 32'(lsu_done_wfid), 7);
        chk("t3_cnt1", 32'(outstanding_cnt), 1);
        cyc();
        chk("t3_mid39", 32'(lsu_done), 0);
        cyc();
        mem_rsp_valid = 1'b0;
        chk("t3_done39", 32'(lsu_done), 1);
        chk("t3_wfid39", 32'(lsu_done_wfid), 39);
        chk("t3_cnt0", 32'(outstanding_cnt), 0);
        cyc();
        chk("t3_done_off", 32'(lsu_done), 0);

        // 4: fill with wfid 10..17, overflow with 50, retire one
        for (int i = 0; i < 8; i++) begin
            set_issue(1'b1, 6'(10 + i), 4'd1);
            cyc();
        end
        set_issue(1'b0, 6'd0, 4'd0);
        chk("t4_cnt8", 32'(outstanding_cnt), 8);
        chk("t4_not_ready", 32'(issue_ready), 0);
        chk("t4_no_ovf_yet", 32'(err_overflow), 0);
        set_issue(1'b1, 6'd50, 4'd1); cyc();
        set_issue(1'b0, 6'd0, 4'd0);
        chk("t4_ovf", 32'(err_overflow), 1);
        chk("t4_cnt_still8", 32'(outstanding_cnt), 8);
        mem_rsp_valid = 1'b1; cyc();
        mem_rsp_valid = 1'b0;
        chk("t4_done10", 32'(lsu_done), 1);
        chk("t4_wfid10", 32'(lsu_done_wfid), 10);
        chk("t4_cnt7", 32'(outstanding_cnt), 7);
        chk("t4_ready", 32'(issue_ready), 1);

        // 6: full + retire with rejected push; then push+retire at 7
        set_issue(1'b1, 6'd20, 4'd1); cyc();
        chk("t6_cnt8", 32'(outstanding_cnt), 8);
        set_issue(1'b1, 6'd51, 4'd1);
        mem_rsp_valid = 1'b1; cyc();
        chk("t6_done11", 32'(lsu_done_wfid), 11);
        chk("t6_cnt7", 32'(outstanding_cnt), 7);
        set_issue(1'b1, 6'd21, 4'd1); cyc();
        set_issue(1'b0, 6'd0, 4'd0);
        chk("t6_done12", 32'(lsu_done_wfid), 12);
        chk("t6_cnt_kept7", 32'(outstanding_cnt), 7);
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("t6_drain_done", 32'(lsu_done), 1);
            chk("t6_drain_wfid", 32'(lsu_done_wfid), 32'(drain_wfid[i]));
            chk("t6_drain_cnt", 32'(outstanding_cnt), 32'(6 - i));
        end
        mem_rsp_valid = 1'b0;
        chk("t6_no_unexp", 32'(err_unexp_rsp), 0);
        cyc();
        chk("t6_idle", 32'(lsu_done), 0);

        // 5: beat with empty queue
        mem_rsp_valid = 1'b1; cyc();
        mem_rsp_valid = 1'b0;
        chk("t5_unexp", 32'(err_unexp_rsp), 1);
        chk("t5_no_done", 32'(lsu_done), 0);
        chk("t5_cnt0", 32'(outstanding_cnt), 0);
        cyc();
        chk("t5_sticky", 32'(err_unexp_rsp), 1);
        chk("t5_ready", 32'(issue_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
